fp_int_systolic: RTL and testbench

- N×N array of FP16-activation × bit-serial signed-integer-weight MAC processing elements (PEs), each with a 32-bit fixed-point accumulator.
- Activations enter at the left edge (one per row) and flow right; weight bits enter at the top (one per column) and flow down.
- Every PE accumulates FP16 activations aligned to a shared exponent (exp_set).
- Sits between the activation/weight feeders and the output drain of the FP-INT MAC datapath.

---
 rtl/fp_int_pkg.sv | 41 ++++
 rtl/fp_int_pe.sv | 84 ++++++++
 rtl/fp_int_systolic.sv | 80 ++++++++
 tb/tb_fp_int_systolic.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_int_pkg.sv
// Shared constants and helpers for the FP16 x bit-serial-integer systolic MAC array.
package fp_int_pkg;

  localparam int ACT_WIDTH     = 16;
  localparam int ACC_WIDTH     = 32;
  localparam int EXP_W         = 5;
  localparam int MAN_W         = 10;
  localparam int SIGN_BIT      = ACT_WIDTH - 1;
  localparam int MAX_PRECISION = 8;
  localparam int K_W           = 3;
  localparam int WIDE_W        = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Aligned signed fixed-point value of an FP16 activation against the shared exponent.
  function automatic wide_t align_fp16(input logic [ACT_WIDTH-1:0] act,
                                       input logic [EXP_W-1:0]     exp_set);
    logic [EXP_W-1:0] e;
    wide_t            mag;
    e   = act[MAN_W +: EXP_W];
    mag = '0;
    mag[MAN_W:0] = {1'b1, act[MAN_W-1:0]};
    if (e == '0)
      return '0;
    if (e >= exp_set)
      mag = mag << (e - exp_set);
    else
      mag = mag >> (exp_set - e);
    return act[SIGN_BIT] ? -mag : mag;
  endfunction

  // Index of the weight MSB for a requested precision, clamped to 1..MAX_PRECISION bits.
  function automatic logic [K_W-1:0] last_bit(input logic [3:0] precision);
    if (precision == 4'd0)
      return '0;
    if (precision > 4'(MAX_PRECISION))
      return K_W'(MAX_PRECISION - 1);
    return K_W'(precision - 4'd1);
  endfunction

endpackage

// File: rtl/fp_int_pe.sv
// Single PE: FP16 alignment, bit-serial signed-weight MAC and pass-through registers.
// Define SATURATE_EN to clamp the accumulator instead of wrapping.
module fp_int_pe
  import fp_int_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ACT_WIDTH-1:0] act,
  input  logic                 w,
  input  logic                 active,
  input  logic [K_W-1:0]       k_last,
  input  logic [EXP_W-1:0]     exp_set,
  output logic [ACT_WIDTH-1:0] act_pass,
  output logic                 w_pass,
  output logic                 active_pass,
  output logic [EXP_W-1:0]     exp_out,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [K_W-1:0]       k;
  wide_t                a_hold;
  wide_t                a_now;
  wide_t                a_use;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] acc_next;

`ifdef SATURATE_EN
  localparam wide_t SAT_MAX = (wide_t'(1) <<< (ACC_WIDTH - 1)) - wide_t'(1);
  localparam wide_t SAT_MIN = -(wide_t'(1) <<< (ACC_WIDTH - 1));
  wide_t sum;
`else
  logic [ACC_WIDTH-1:0] term;
`endif

  // active_pass is the previous cycle's active, so a low value marks the first cycle of a job.
  always_comb begin
    a_now    = align_fp16(act, exp_set);
    a_use    = (k == '0) ? a_now : a_hold;
    base     = active_pass ? acc : '0;
    acc_next = base;
`ifdef SATURATE_EN
    sum = {{(WIDE_W-ACC_WIDTH){base[ACC_WIDTH-1]}}, base};
    if (w)
      sum = (k == k_last) ? sum - (a_use <<< k) : sum + (a_use <<< k);
    if (sum > SAT_MAX)
      acc_next = SAT_MAX[ACC_WIDTH-1:0];
    else if (sum < SAT_MIN)
      acc_next = SAT_MIN[ACC_WIDTH-1:0];
    else
      acc_next = sum[ACC_WIDTH-1:0];
`else
    term = ACC_WIDTH'(a_use <<< k);
    if (w)
      acc_next = (k == k_last) ? base - term : base + term;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_pass    <= '0;
      w_pass      <= 1'b0;
      active_pass <= 1'b0;
      k           <= '0;
      a_hold      <= '0;
      exp_out     <= '0;
      acc         <= '0;
    end else begin
      act_pass    <= act;
      w_pass      <= w;
      active_pass <= active;
      if (active) begin
        k <= (k >= k_last) ? '0 : k + 1'b1;
        if (k == '0)
          a_hold <= a_now;
        if (!active_pass)
          exp_out <= exp_set;
        acc <= acc_next;
      end else begin
        k <= '0;
      end
    end
  end

endmodule

// File: rtl/fp_int_systolic.sv
// N x N FP16-activation x bit-serial-weight systolic array with edge skew and done detect.
// Optional SATURATE_EN (see fp_int_pe) clamps accumulators; exp_set/precision are job-static.
module fp_int_systolic
  import fp_int_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       active,
  input  logic [3:0]                 precision,
  input  logic [EXP_W-1:0]           exp_set,
  input  logic [N*ACT_WIDTH-1:0]     act_in,
  input  logic [N-1:0]               w_in,
  output logic                       done,
  output logic [N*N*EXP_W-1:0]       exp_out,
  output logic [N*N*ACC_WIDTH-1:0]   acc_out
);

  logic [ACT_WIDTH-1:0] h_act    [N][N+1];
  logic                 h_active [N][N+1];
  logic                 v_w      [N+1][N];
  logic [K_W-1:0]       k_last;

  assign k_last = last_bit(precision);

  // Edge e carries row e's {active, activation} and column e's weight bit, delayed e cycles.
  for (genvar e = 0; e < N; e++) begin : g_edge
    if (e == 0) begin : g_direct
      assign h_act[0][0]    = act_in[0 +: ACT_WIDTH];
      assign h_active[0][0] = active;
      assign v_w[0][0]      = w_in[0];
    end else begin : g_skew
      logic [ACT_WIDTH+1:0] dly [e];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < e; d++)
            dly[d] <= '0;
        end else begin
          dly[0] <= {active, act_in[e*ACT_WIDTH +: ACT_WIDTH], w_in[e]};
          for (int d = 1; d < e; d++)
            dly[d] <= dly[d-1];
        end
      end
      assign h_active[e][0] = dly[e-1][ACT_WIDTH+1];
      assign h_act[e][0]    = dly[e-1][ACT_WIDTH:1];
      assign v_w[0][e]      = dly[e-1][0];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      fp_int_pe u_pe (
        .clk         (clk),
        .rst         (rst),
        .act         (h_act[i][j]),
        .w           (v_w[i][j]),
        .active      (h_active[i][j]),
        .k_last      (k_last),
        .exp_set     (exp_set),
        .act_pass    (h_act[i][j+1]),
        .w_pass      (v_w[i+1][j]),
        .active_pass (h_active[i][j+1]),
        .exp_out     (exp_out[(i*N+j)*EXP_W +: EXP_W]),
        .acc         (acc_out[(i*N+j)*ACC_WIDTH +: ACC_WIDTH])
      );
    end
  end

  // The last PE's pass-through active is its own previous active, giving the 1->0 edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      done <= 1'b0;
    else if (active)
      done <= 1'b0;
    else if (!h_active[N-1][N-1] && h_active[N-1][N])
      done <= 1'b1;
  end

endmodule

// File: tb/tb_fp_int_systolic.sv
// Scoreboard bench for fp_int_systolic: expected PE results queued per job, compared at done.
module tb_fp_int_systolic;
  import fp_int_pkg::*;

  localparam int N = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     active;
  logic [3:0]               precision;
  logic [EXP_W-1:0]         exp_set;
  logic [N*ACT_WIDTH-1:0]   act_in;
  logic [N-1:0]             w_in;
  logic                     done;
  logic [N*N*EXP_W-1:0]     exp_out;
  logic [N*N*ACC_WIDTH-1:0] acc_out;

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] acc;
    logic [4:0]  exp;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] act_tab [N][4];
  logic [7:0]  wt_tab  [N][4];
  int          checks = 0;
  int          errors = 0;

  fp_int_systolic #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .active    (active),
    .precision (precision),
    .exp_set   (exp_set),
    .act_in    (act_in),
    .w_in      (w_in),
    .done      (done),
    .exp_out   (exp_out),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  function automatic longint model_act(input logic [15:0] a, input logic [4:0] es);
    longint m;
    int     d;
    if (a[14:10] == 5'd0)
      return 0;
    m = 1024 + longint'(a[9:0]);
    d = int'(a[14:10]) - int'(es);
    if (d >= 0)
      m = m <<< d;
    else
      m = m >>> (-d);
    return a[15] ? -m : m;
  endfunction

  function automatic longint model_wt(input logic [7:0] w, input int p);
    longint v;
    v = longint'(w) & ((longint'(1) <<< p) - 1);
    if (w[p-1])
      v = v - (longint'(1) <<< p);
    return v;
  endfunction

  function automatic int clamp_p(input int p);
    if (p == 0)
      return 1;
    if (p > 8)
      return 8;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // One job: queue expected results, stream windows, wait for done, drain the scoreboard.
  task automatic applyStimulus(input string tag, input int praw, input logic [4:0] es,
                               input int nwin);
    int          p;
    int          cyc;
    longint      sum;
    exp_t        e;
    int          last_idx;
    logic [31:0] last_acc;
    p = clamp_p(praw);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int w = 0; w < nwin; w++)
          sum += model_act(act_tab[i][w], es) * model_wt(wt_tab[j][w], p);
        sb.push_back('{tag, i*N+j, sum[31:0], es});
      end
    precision = praw[3:0];
    exp_set   = es;
    for (int w = 0; w < nwin; w++)
      for (int k = 0; k < p; k++) begin
        @(negedge clk);
        active = 1'b1;
        for (int i = 0; i < N; i++)
          act_in[i*ACT_WIDTH +: ACT_WIDTH] = (k == 0) ? act_tab[i][w] : 16'($urandom);
        for (int j = 0; j < N; j++)
          w_in[j] = wt_tab[j][w][k];
      end
    @(negedge clk);
    active = 1'b0;
    act_in = '0;
    w_in   = '0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_done_lat"}, 64'(cyc), 64'(2*(N-1)+1));
    last_idx = 0;
    last_acc = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("%s_acc%0d", e.tag, e.idx),
                  64'(acc_out[e.idx*ACC_WIDTH +: ACC_WIDTH]), 64'(e.acc));
      checkOutput($sformatf("%s_exp%0d", e.tag, e.idx),
                  64'(exp_out[e.idx*EXP_W +: EXP_W]), 64'(e.exp));
      last_idx = e.idx;
      last_acc = e.acc;
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_hold"}, 64'(acc_out[last_idx*ACC_WIDTH +: ACC_WIDTH]), 64'(last_acc));
    checkOutput({tag, "_done_hold"}, 64'(done), 64'(1));
  endtask

  task automatic setJob(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [7:0] w0, input logic [7:0] w1, input int win);
    act_tab[0][win] = a0;
    act_tab[1][win] = a1;
    wt_tab[0][win]  = w0;
    wt_tab[1][win]  = w1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    active    = 1'b0;
    precision = 4'd4;
    exp_set   = 5'd15;
    act_in    = '0;
    w_in      = '0;
    #12;
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_acc", 64'(acc_out), 64'(0));
    checkOutput("reset_exp", 64'(exp_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    setJob(16'h3C00, 16'h3C00, 8'h0F, 8'h0F, 0);
    applyStimulus("neg1", 4, 5'd15, 1);

    setJob(16'h3C00, 16'h4000, 8'h0F, 8'h05, 0);
    setJob(16'h4200, 16'hC000, 8'h0F, 8'h03, 1);
    applyStimulus("twowin", 4, 5'd15, 2);

    setJob(16'h4000, 16'hC000, 8'h05, 8'h03, 0);
    applyStimulus("pos", 4, 5'd15, 1);

    setJob(16'h3C00, 16'h0000, 8'h80, 8'hFF, 0);
    applyStimulus("p8", 8, 5'd15, 1);

    setJob(16'h3C00, 16'h0001, 8'h01, 8'h07, 0);
    applyStimulus("es16", 4, 5'd16, 1);

    setJob(16'h3C00, 16'h4000, 8'h01, 8'h00, 0);
    applyStimulus("pclamp0", 0, 5'd15, 1);

    setJob(16'h3555, 16'hBE00, 8'h7F, 8'hA5, 0);
    setJob(16'h4A10, 16'h0000, 8'h81, 8'h3C, 1);
    applyStimulus("pclamp12", 12, 5'd14, 2);

    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++)
        setJob(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), w);
      applyStimulus($sformatf("rand%0d", r), $urandom_range(1, 8),
                    5'($urandom_range(10, 20)), $urandom_range(1, 4));
    end

    // Asynchronous reset in the middle of a job.
    precision = 4'd4;
    exp_set   = 5'd17;
    repeat (3) begin
      @(negedge clk);
      active = 1'b1;
      act_in = {16'h4400, 16'h4400};
      w_in   = 2'b11;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_acc", 64'(acc_out), 64'(0));
    checkOutput("midrst_exp", 64'(exp_out), 64'(0));
    checkOutput("midrst_done", 64'(done), 64'(0));
    @(negedge clk);
    active = 1'b0;
    act_in = '0;
    w_in   = '0;
    rst    = 1'b0;

    setJob(16'hC200, 16'h3C00, 8'h06, 8'h09, 0);
    applyStimulus("postrst", 4, 5'd15, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
